// File: rtl/tft_paint_pkg.sv
// Shared types, state codes and screen constants for the touch paint scheduler.
// Also holds the brush walker helper used to skip off-screen brush pixels.
package tft_paint_pkg;

    typedef logic [8:0] coord_t;
    typedef logic [8:0] color_t;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOCK  = 2'd1;
    localparam state_t ST_PAINT = 2'd2;
    localparam state_t ST_CLEAR = 2'd3;

    localparam int SCR_W_DEFAULT = 480;
    localparam int SCR_H_DEFAULT = 272;

    // Brush pixels are numbered 0..8 in raster order; 9 means "no pixel left".
    localparam logic [3:0] BRUSH_NONE = 4'd9;

    function automatic logic [3:0] first_brush_pixel(input logic [8:0] mask,
                                                     input logic [3:0] start);
        logic [3:0] found;
        found = BRUSH_NONE;
        for (int i = 8; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= start)) begin
                found = 4'(i);
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/touch_paint_scheduler_if.sv
// Framebuffer write bus between the paint scheduler (master) and the TFT driver (slave).
interface touch_paint_scheduler_if;
    import tft_paint_pkg::*;

    logic   wr_ena;
    coord_t wr_x;
    coord_t wr_y;
    color_t wr_data;
    logic   wr_ready;

    modport master (output wr_ena, wr_x, wr_y, wr_data, input wr_ready);
    modport slave  (input wr_ena, wr_x, wr_y, wr_data, output wr_ready);

endinterface

// File: rtl/touch_coord_scaler.sv
// Combinational raw-touch to screen-coordinate conversion with on-screen validity.
module touch_coord_scaler
    import tft_paint_pkg::*;
#(
    parameter int X_OFFSET = 150,
    parameter int Y_OFFSET = 300,
    parameter int X_SHIFT  = 3,
    parameter int Y_SHIFT  = 4,
    parameter int Z_THRESH = 256,
    parameter int SCR_W    = SCR_W_DEFAULT,
    parameter int SCR_H    = SCR_H_DEFAULT
) (
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    input  logic [11:0] touch_z,
    output coord_t      px,
    output coord_t      py,
    output logic        valid
);

    logic [11:0] diff_x;
    logic [11:0] diff_y;
    logic [11:0] wide_x;
    logic [11:0] wide_y;

    // Offsets below the minimum are rejected rather than wrapped or clamped.
    always_comb begin
        diff_x = touch_x - 12'(X_OFFSET);
        diff_y = touch_y - 12'(Y_OFFSET);
        wide_x = diff_x >> X_SHIFT;
        wide_y = diff_y >> Y_SHIFT;
        px     = wide_x[8:0];
        py     = wide_y[8:0];
        valid  = (touch_z >= 12'(Z_THRESH))
              && (touch_x >= 12'(X_OFFSET))
              && (touch_y >= 12'(Y_OFFSET))
              && (wide_x < 12'(SCR_W))
              && (wide_y < 12'(SCR_H));
    end

endmodule

// File: rtl/touch_paint_scheduler.sv
// Paints a 3x3 brush at the touched pixel once per frame, or clears the whole framebuffer.
// Optional TOUCH_DEBOUNCE_EN: a sample also needs a touch at the previous accepted frame.
module touch_paint_scheduler
    import tft_paint_pkg::*;
#(
    parameter int X_OFFSET = 150,
    parameter int Y_OFFSET = 300,
    parameter int X_SHIFT  = 3,
    parameter int Y_SHIFT  = 4,
    parameter int Z_THRESH = 256,
    parameter int SCR_W    = SCR_W_DEFAULT,
    parameter int SCR_H    = SCR_H_DEFAULT
) (
    input  logic        cclk,
    input  logic        reset,
    input  logic [11:0] touch_x,
    input  logic [11:0] touch_y,
    input  logic [11:0] touch_z,
    input  logic        new_frame,
    input  logic        clear_req,
    input  color_t      paint_color,
    input  color_t      bg_color,
    output logic        busy,
    touch_paint_scheduler_if.master wr
);

    state_t     state;
    coord_t     px;
    coord_t     py;
    logic [3:0] bidx;
    logic       clear_pend;

    coord_t     scaled_x;
    coord_t     scaled_y;
    logic       scaled_valid;
    logic       sample_ok;

    touch_coord_scaler #(
        .X_OFFSET (X_OFFSET),
        .Y_OFFSET (Y_OFFSET),
        .X_SHIFT  (X_SHIFT),
        .Y_SHIFT  (Y_SHIFT),
        .Z_THRESH (Z_THRESH),
        .SCR_W    (SCR_W),
        .SCR_H    (SCR_H)
    ) u_scaler (
        .touch_x (touch_x),
        .touch_y (touch_y),
        .touch_z (touch_z),
        .px      (scaled_x),
        .py      (scaled_y),
        .valid   (scaled_valid)
    );

`ifdef TOUCH_DEBOUNCE_EN
    logic touch_hist;

    assign sample_ok = scaled_valid && touch_hist;

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            touch_hist <= 1'b0;
        end else if (state == ST_LOCK) begin
            touch_hist <= (touch_z >= 12'(Z_THRESH));
        end
    end
`else
    assign sample_ok = scaled_valid;
`endif

    coord_t     ctr_x;
    coord_t     ctr_y;
    coord_t     next_x;
    coord_t     next_y;
    logic [3:0] start_idx;
    logic [3:0] next_idx;
    logic [2:0] col_ok;
    logic [2:0] row_ok;
    logic [8:0] brush_mask;
    logic       brush_done;

    // LOCK looks up the first brush pixel from the live sample so PAINT starts with no bubble;
    // PAINT looks for the next on-screen pixel after the one just accepted.
    always_comb begin
        if (state == ST_LOCK) begin
            ctr_x     = scaled_x;
            ctr_y     = scaled_y;
            start_idx = 4'd0;
        end else begin
            ctr_x     = px;
            ctr_y     = py;
            start_idx = bidx + 4'd1;
        end
        col_ok[0] = (ctr_x != '0);
        col_ok[1] = 1'b1;
        col_ok[2] = (({1'b0, ctr_x} + 10'd1) < 10'(SCR_W));
        row_ok[0] = (ctr_y != '0);
        row_ok[1] = 1'b1;
        row_ok[2] = (({1'b0, ctr_y} + 10'd1) < 10'(SCR_H));
        for (int i = 0; i < 9; i++) begin
            brush_mask[i] = col_ok[i % 3] & row_ok[i / 3];
        end
        next_idx   = first_brush_pixel(brush_mask, start_idx);
        brush_done = (next_idx == BRUSH_NONE);
        next_x     = ctr_x + coord_t'(next_idx % 4'd3) - 9'd1;
        next_y     = ctr_y + coord_t'(next_idx / 4'd3) - 9'd1;
    end

    assign busy = (state != ST_IDLE);

    // Write bus registers only move on an accepted write, so they hold steady through stalls.
    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            px         <= '0;
            py         <= '0;
            bidx       <= '0;
            clear_pend <= 1'b0;
            wr.wr_ena  <= 1'b0;
            wr.wr_x    <= '0;
            wr.wr_y    <= '0;
            wr.wr_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state      <= ST_CLEAR;
                        wr.wr_ena  <= 1'b1;
                        wr.wr_x    <= '0;
                        wr.wr_y    <= '0;
                        wr.wr_data <= bg_color;
                    end else if (new_frame) begin
                        state <= ST_LOCK;
                    end
                end

                ST_LOCK: begin
                    px <= scaled_x;
                    py <= scaled_y;
                    if (sample_ok) begin
                        state      <= ST_PAINT;
                        bidx       <= next_idx;
                        wr.wr_ena  <= 1'b1;
                        wr.wr_x    <= next_x;
                        wr.wr_y    <= next_y;
                        wr.wr_data <= paint_color;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_PAINT: begin
                    if (clear_req) begin
                        clear_pend <= 1'b1;
                    end
                    if (wr.wr_ena && wr.wr_ready) begin
                        if (!brush_done) begin
                            bidx       <= next_idx;
                            wr.wr_x    <= next_x;
                            wr.wr_y    <= next_y;
                            wr.wr_data <= paint_color;
                        end else if (clear_req || clear_pend) begin
                            state      <= ST_CLEAR;
                            clear_pend <= 1'b0;
                            wr.wr_x    <= '0;
                            wr.wr_y    <= '0;
                            wr.wr_data <= bg_color;
                        end else begin
                            state      <= ST_IDLE;
                            clear_pend <= 1'b0;
                            wr.wr_ena  <= 1'b0;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (wr.wr_ena && wr.wr_ready) begin
                        wr.wr_data <= bg_color;
                        if (wr.wr_x == coord_t'(SCR_W - 1)) begin
                            wr.wr_x <= '0;
                            if (wr.wr_y == coord_t'(SCR_H - 1)) begin
                                state     <= ST_IDLE;
                                wr.wr_ena <= 1'b0;
                                wr.wr_y   <= '0;
                            end else begin
                                wr.wr_y <= wr.wr_y + 9'd1;
                            end
                        end else begin
                            wr.wr_x <= wr.wr_x + 9'd1;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    wr.wr_ena <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_paint_scheduler.sv
// Randomized bench for touch_paint_scheduler: a full-size and an 8x4 instance share stimulus
// and every accepted write is checked against a pixel-list reference model.
module tb_touch_paint_scheduler;
    import tft_paint_pkg::*;

    typedef struct packed {
        coord_t x;
        coord_t y;
        color_t d;
    } wr_t;

    logic        cclk = 1'b0;
    logic        reset;
    logic [11:0] touch_x;
    logic [11:0] touch_y;
    logic [11:0] touch_z;
    logic        new_frame;
    logic        clear_big;
    logic        clear_small;
    logic        wr_ready;
    logic        rand_ready;
    color_t      paint_color;
    color_t      bg_color;
    logic        busy_big;
    logic        busy_small;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wr_t log_big[$];
    wr_t log_small[$];
    int  cyc_small[$];
    wr_t exp_big[$];
    wr_t exp_small[$];

    touch_paint_scheduler_if bus_big();
    touch_paint_scheduler_if bus_small();

    assign bus_big.wr_ready   = wr_ready;
    assign bus_small.wr_ready = wr_ready;

    touch_paint_scheduler dut_big (
        .cclk        (cclk),
        .reset       (reset),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .touch_z     (touch_z),
        .new_frame   (new_frame),
        .clear_req   (clear_big),
        .paint_color (paint_color),
        .bg_color    (bg_color),
        .busy        (busy_big),
        .wr          (bus_big)
    );

    touch_paint_scheduler #(.SCR_W(8), .SCR_H(4)) dut_small (
        .cclk        (cclk),
        .reset       (reset),
        .touch_x     (touch_x),
        .touch_y     (touch_y),
        .touch_z     (touch_z),
        .new_frame   (new_frame),
        .clear_req   (clear_small),
        .paint_color (paint_color),
        .bg_color    (bg_color),
        .busy        (busy_small),
        .wr          (bus_small)
    );

    always #5 cclk = ~cclk;

    always @(posedge cclk) cyc++;

    always @(posedge cclk) begin
        #1;
        if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, got, want);
        end
    endtask

    // Write monitor: logs accepted writes, and checks stall holding and busy during writes.
    wr_t  prev_big;
    wr_t  prev_small;
    logic stall_big   = 1'b0;
    logic stall_small = 1'b0;

    always @(negedge cclk) begin
        if (reset) begin
            stall_big   = 1'b0;
            stall_small = 1'b0;
        end else begin
            if (bus_big.wr_ena) checkOutput("busy_big_write", busy_big, 1);
            if (stall_big)
                checkOutput("hold_big", {bus_big.wr_ena, bus_big.wr_x, bus_big.wr_y, bus_big.wr_data},
                            {1'b1, prev_big});
            if (bus_big.wr_ena && wr_ready)
                log_big.push_back(wr_t'({bus_big.wr_x, bus_big.wr_y, bus_big.wr_data}));
            stall_big = bus_big.wr_ena && !wr_ready;
            prev_big  = wr_t'({bus_big.wr_x, bus_big.wr_y, bus_big.wr_data});

            if (bus_small.wr_ena) checkOutput("busy_small_write", busy_small, 1);
            if (stall_small)
                checkOutput("hold_small", {bus_small.wr_ena, bus_small.wr_x, bus_small.wr_y, bus_small.wr_data},
                            {1'b1, prev_small});
            if (bus_small.wr_ena && wr_ready) begin
                log_small.push_back(wr_t'({bus_small.wr_x, bus_small.wr_y, bus_small.wr_data}));
                cyc_small.push_back(cyc);
            end
            stall_small = bus_small.wr_ena && !wr_ready;
            prev_small  = wr_t'({bus_small.wr_x, bus_small.wr_y, bus_small.wr_data});
        end
    end

    task automatic clear_queues();
        log_big.delete();
        log_small.delete();
        cyc_small.delete();
        exp_big.delete();
        exp_small.delete();
    endtask

    // Reference model: the list of on-screen pixels of a 3x3 brush around the scaled touch.
    task automatic build_expected(input int tx, input int ty, input int tz,
                                  input bit small_scr, input color_t c);
        int w, h, px, py;
        w = small_scr ? 8 : 480;
        h = small_scr ? 4 : 272;
        if (tz < 256 || tx < 150 || ty < 300) return;
        px = (tx - 150) / 8;
        py = (ty - 300) / 16;
        if (px >= w || py >= h) return;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (px + dx >= 0 && px + dx < w && py + dy >= 0 && py + dy < h) begin
                    if (small_scr) exp_small.push_back('{coord_t'(px + dx), coord_t'(py + dy), c});
                    else           exp_big.push_back('{coord_t'(px + dx), coord_t'(py + dy), c});
                end
            end
        end
    endtask

    task automatic expect_clear(input color_t c);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                exp_small.push_back('{coord_t'(x), coord_t'(y), c});
    endtask

    task automatic compare_logs(input string tag);
        checkOutput({tag, "_big_count"}, log_big.size(), exp_big.size());
        for (int i = 0; i < exp_big.size() && i < log_big.size(); i++)
            checkOutput($sformatf("%s_big[%0d]", tag, i), log_big[i], exp_big[i]);
        checkOutput({tag, "_small_count"}, log_small.size(), exp_small.size());
        for (int i = 0; i < exp_small.size() && i < log_small.size(); i++)
            checkOutput($sformatf("%s_small[%0d]", tag, i), log_small[i], exp_small[i]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge cclk);
            done = !busy_big && !busy_small;
        end
        checkOutput({tag, "_done"}, done, 1);
    endtask

    task automatic pulse_frame();
        @(posedge cclk); #1 new_frame = 1'b1;
        @(posedge cclk); #1 new_frame = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input int tx, input int ty, input int tz, input bit rnd);
        clear_queues();
        paint_color = 9'($urandom);
        touch_x = 12'(tx);
        touch_y = 12'(ty);
        touch_z = 12'(tz);
        build_expected(tx, ty, tz, 1'b0, paint_color);
        build_expected(tx, ty, tz, 1'b1, paint_color);
        rand_ready = rnd;
        pulse_frame();
        @(negedge cclk);
        checkOutput({tag, "_lock_busy"}, {busy_big, busy_small}, 2'b11);
        checkOutput({tag, "_lock_wr_ena"}, {bus_big.wr_ena, bus_small.wr_ena}, 2'b00);
        wait_idle(tag, 300);
        rand_ready = 1'b0;
        wr_ready   = 1'b1;
        checkOutput({tag, "_idle_wr_ena"}, {bus_big.wr_ena, bus_small.wr_ena}, 2'b00);
        compare_logs(tag);
    endtask

    task automatic run_clear(input string tag, input bit rnd);
        clear_queues();
        bg_color = 9'($urandom);
        expect_clear(bg_color);
        rand_ready = rnd;
        @(posedge cclk); #1 clear_small = 1'b1;
        @(posedge cclk); #1 clear_small = 1'b0;
        @(negedge cclk);
        checkOutput({tag, "_start"}, {busy_small, bus_small.wr_ena}, 2'b11);
        wait_idle(tag, 400);
        rand_ready = 1'b0;
        wr_ready   = 1'b1;
        compare_logs(tag);
        if (!rnd) checkOutput({tag, "_span"}, cyc_small[31] - cyc_small[0], 31);
    endtask

    initial begin
        reset       = 1'b1;
        touch_x     = '0;
        touch_y     = '0;
        touch_z     = '0;
        new_frame   = 1'b0;
        clear_big   = 1'b0;
        clear_small = 1'b0;
        wr_ready    = 1'b1;
        rand_ready  = 1'b0;
        paint_color = 9'h1C3;
        bg_color    = 9'h02A;
        repeat (3) @(posedge cclk);
        @(negedge cclk);
        checkOutput("rst_big", {busy_big, bus_big.wr_ena, bus_big.wr_x, bus_big.wr_y, bus_big.wr_data}, 0);
        checkOutput("rst_small", {busy_small, bus_small.wr_ena, bus_small.wr_x, bus_small.wr_y, bus_small.wr_data}, 0);
        reset = 1'b0;
        repeat (2) @(negedge cclk);
        checkOutput("post_rst_idle", {busy_big, busy_small, bus_big.wr_ena, bus_small.wr_ena}, 0);

        applyStimulus("centre", 1350, 2000, 1000, 1'b0);
        checkOutput("centre_first_xy", {log_big[0].x, log_big[0].y}, {9'd149, 9'd105});
        checkOutput("centre_last_xy", {log_big[8].x, log_big[8].y}, {9'd151, 9'd107});
        applyStimulus("origin", 150, 300, 1000, 1'b0);
        applyStimulus("light_touch", 1350, 2000, 100, 1'b0);
        applyStimulus("left_of_offset", 100, 2000, 1000, 1'b0);
        applyStimulus("corner_small", 206, 348, 1000, 1'b0);
        applyStimulus("right_edge", 3982, 2000, 1000, 1'b0);
        applyStimulus("off_right", 3990, 2000, 1000, 1'b0);
        applyStimulus("centre_stall", 1350, 2000, 1000, 1'b1);

        for (int n = 0; n < 24; n++) begin
            int tx, ty, tz;
            if (n % 2 == 1) begin
                tx = $urandom_range(0, 4095);
                ty = $urandom_range(250, 4095);
            end else begin
                tx = $urandom_range(140, 225);
                ty = $urandom_range(290, 370);
            end
            tz = ($urandom_range(0, 1) == 1) ? $urandom_range(256, 4095) : $urandom_range(0, 300);
            applyStimulus($sformatf("rand%0d", n), tx, ty, tz, 1'b1);
        end

        run_clear("clear", 1'b0);
        run_clear("clear_stall", 1'b1);

        // Clear request arriving mid-brush must follow the brush with no idle gap.
        clear_queues();
        paint_color = 9'($urandom);
        bg_color    = 9'($urandom);
        touch_x = 12'd174;
        touch_y = 12'd316;
        touch_z = 12'd1000;
        build_expected(174, 316, 1000, 1'b0, paint_color);
        build_expected(174, 316, 1000, 1'b1, paint_color);
        expect_clear(bg_color);
        pulse_frame();
        for (int i = 0; i < 50 && log_small.size() < 2; i++) @(negedge cclk);
        clear_small = 1'b1;
        @(posedge cclk); #1 clear_small = 1'b0;
        wait_idle("brush_clear", 500);
        compare_logs("brush_clear");
        checkOutput("clear_follows_brush", cyc_small[9] - cyc_small[8], 1);

        // Reset in the middle of a clear aborts it and nothing is written afterwards.
        clear_queues();
        bg_color = 9'($urandom);
        @(posedge cclk); #1 clear_small = 1'b1;
        @(posedge cclk); #1 clear_small = 1'b0;
        for (int i = 0; i < 50 && log_small.size() < 10; i++) @(negedge cclk);
        checkOutput("mid_clear_busy", busy_small, 1);
        #2 reset = 1'b1;
        @(posedge cclk); @(posedge cclk); #1;
        checkOutput("abort_state", {busy_small, bus_small.wr_ena, bus_small.wr_x, bus_small.wr_y, bus_small.wr_data}, 0);
        reset = 1'b0;
        log_big.delete();
        log_small.delete();
        repeat (40) @(negedge cclk);
        checkOutput("no_writes_after_reset", log_small.size() + log_big.size(), 0);
        checkOutput("idle_after_reset", {busy_small, bus_small.wr_ena}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
